// File: rtl/btisa_decode_stage.sv
// Balanced-ternary ISA decode stage.
// Each trit is encoded in 2 bits: 2'b00 = 0, 2'b01 = +1, 2'b10 = -1, 2'b11 = invalid.
// The instruction is laid out MSB to LSB as opcode (3 trits), rd, rs1, rs2/imm.
// Holds two decoded bundles: an output register plus a skid register.
// valid/ready: a transfer happens on a rising clk edge where valid and ready are both 1.
// in_ready is registered, so it never depends combinationally on out_ready.
module btisa_decode_stage #(
    parameter int REG_TRITS  = 2,
    parameter int IMM_TRITS  = 2,
    parameter int DATA_TRITS = 9
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2*(3+2*REG_TRITS+IMM_TRITS)-1:0] in_instr,
    input  logic                      flush,
    input  logic                      resume,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [5:0]                out_opcode,
    output logic [2*REG_TRITS-1:0]    out_rd,
    output logic [2*REG_TRITS-1:0]    out_rs1,
    output logic [2*IMM_TRITS-1:0]    out_rs2_imm,
    output logic [2*DATA_TRITS-1:0]   out_imm_ext,
    output logic                      out_reg_write,
    output logic                      out_mem_read,
    output logic                      out_mem_write,
    output logic                      out_branch,
    output logic                      out_jump,
    output logic                      out_alu_src,
    output logic                      out_halt,
    output logic                      out_ecall,
    output logic                      out_illegal,
    output logic [2:0]                out_alu_op,
    output logic                      halted,
    output logic [7:0]                illegal_count
);

    localparam int INSTR_TRITS = 3 + 2*REG_TRITS + IMM_TRITS;
    localparam int IW = 2*INSTR_TRITS;
    localparam int RW = 2*REG_TRITS;
    localparam int MW = 2*IMM_TRITS;
    localparam int BW = IW + 12;

    localparam logic [1:0] T_Z = 2'b00;
    localparam logic [1:0] T_P = 2'b01;
    localparam logic [1:0] T_N = 2'b10;
    localparam logic [1:0] T_X = 2'b11;

    // Control word layout: {reg_write, mem_read, mem_write, branch, jump,
    //                       alu_src, halt, ecall, illegal, alu_op[2:0]}
    function automatic logic [11:0] decode(input logic [IW-1:0] ins);
        logic [11:0] c;
        logic        bad;
        c   = '0;
        bad = 1'b0;
        for (int i = 0; i < INSTR_TRITS; i++) begin
            if (ins[2*i +: 2] == T_X) bad = 1'b1;
        end
        case (ins[IW-1 -: 6])
            {T_Z,T_Z,T_Z}: c = 12'b100_001_000_000; // ADD
            {T_Z,T_Z,T_P}: c = 12'b100_001_000_001; // SUB
            {T_Z,T_Z,T_N}: c = 12'b100_001_000_010; // NEG
            {T_Z,T_P,T_Z}: c = 12'b100_001_000_000; // MUL
            {T_Z,T_P,T_P}: c = 12'b100_001_000_101; // SHL
            {T_Z,T_P,T_N}: c = 12'b100_001_000_110; // SHR
            {T_Z,T_N,T_Z}: c = 12'b100_001_000_000; // ADDI
            {T_N,T_P,T_N}: c = 12'b000_100_000_001; // BEQ
            {T_Z,T_N,T_P}: c = 12'b000_100_000_001; // BNE
            {T_Z,T_N,T_N}: c = 12'b000_100_000_001; // BLT
            {T_P,T_Z,T_Z}: c = 12'b100_000_000_011; // MIN
            {T_P,T_Z,T_P}: c = 12'b100_000_000_100; // MAX
            {T_P,T_Z,T_N}: c = 12'b100_000_000_000; // XOR
            {T_P,T_P,T_Z}: c = 12'b100_000_000_010; // INV
            {T_P,T_P,T_P}: c = 12'b100_000_000_010; // PTI
            {T_P,T_P,T_N}: c = 12'b100_000_000_010; // NTI
            {T_P,T_N,T_Z}: c = 12'b100_011_000_000; // JAL
            {T_P,T_N,T_P}: c = 12'b100_011_000_000; // JALR
            {T_P,T_N,T_N}: c = 12'b000_011_000_000; // JR
            {T_N,T_Z,T_Z}: c = 12'b110_001_000_000; // LD
            {T_N,T_Z,T_P}: c = 12'b001_001_000_000; // ST
            {T_N,T_Z,T_N}: c = 12'b110_001_000_000; // LDT
            {T_N,T_P,T_Z}: c = 12'b001_001_000_000; // STT
            {T_N,T_P,T_P}: c = 12'b100_001_000_000; // LUI
            {T_N,T_N,T_N}: c = 12'b000_000_010_000; // ECALL
            {T_N,T_N,T_P}: c = 12'b000_000_100_000; // HALT
            default:       c = 12'b000_000_000_000; // NOP and invalid opcodes
        endcase
        // Any invalid trit anywhere overrides the decode; fields still pass through.
        if (bad) c = 12'b000_000_001_000;
        return c;
    endfunction

    logic [BW-1:0] out_bundle_q, out_bundle_d;
    logic [BW-1:0] skid_bundle_q, skid_bundle_d;
    logic          out_valid_q, out_valid_d;
    logic          skid_valid_q, skid_valid_d;
    logic          in_ready_q, in_ready_d;
    logic          halted_q, halted_d;
    logic [7:0]    ill_cnt_q, ill_cnt_d;
    logic [11:0]   in_ctrl;
    logic          accept;
    logic          out_free;

    // Next-state for the two-entry buffer, halt state and illegal counter.
    always_comb begin
        out_bundle_d  = out_bundle_q;
        skid_bundle_d = skid_bundle_q;
        out_valid_d   = out_valid_q;
        skid_valid_d  = skid_valid_q;
        halted_d      = halted_q;
        ill_cnt_d     = ill_cnt_q;
        in_ctrl       = decode(in_instr);
        // in_ready_q is only 1 when the skid is empty, so an accept never
        // collides with a held skid entry.
        accept        = in_valid & in_ready_q & ~flush;
        out_free      = ~out_valid_q | out_ready;

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_bundle_d = skid_bundle_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d  = 1'b1;
                out_bundle_d = {in_instr, in_ctrl};
            end else begin
                out_valid_d  = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d  = 1'b1;
            skid_bundle_d = {in_instr, in_ctrl};
        end

        // A HALT accept wins over a same-cycle resume.
        if (accept && in_ctrl[5]) begin
            halted_d = 1'b1;
        end else if (resume) begin
            halted_d = 1'b0;
        end

        if (accept && in_ctrl[3] && (ill_cnt_q != 8'hFF)) begin
            ill_cnt_d = ill_cnt_q + 8'd1;
        end

        in_ready_d = ~skid_valid_d & ~halted_d;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_bundle_q  <= '0;
            skid_bundle_q <= '0;
            out_valid_q   <= 1'b0;
            skid_valid_q  <= 1'b0;
            in_ready_q    <= 1'b0;
            halted_q      <= 1'b0;
            ill_cnt_q     <= 8'd0;
        end else begin
            out_bundle_q  <= out_bundle_d;
            skid_bundle_q <= skid_bundle_d;
            out_valid_q   <= out_valid_d;
            skid_valid_q  <= skid_valid_d;
            in_ready_q    <= in_ready_d;
            halted_q      <= halted_d;
            ill_cnt_q     <= ill_cnt_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign halted        = halted_q;
    assign illegal_count = ill_cnt_q;

    assign out_opcode    = out_bundle_q[BW-1 -: 6];
    assign out_rd        = out_bundle_q[BW-7 -: RW];
    assign out_rs1       = out_bundle_q[BW-7-RW -: RW];
    assign out_rs2_imm   = out_bundle_q[12 +: MW];
    assign out_reg_write = out_bundle_q[11];
    assign out_mem_read  = out_bundle_q[10];
    assign out_mem_write = out_bundle_q[9];
    assign out_branch    = out_bundle_q[8];
    assign out_jump      = out_bundle_q[7];
    assign out_alu_src   = out_bundle_q[6];
    assign out_halt      = out_bundle_q[5];
    assign out_ecall     = out_bundle_q[4];
    assign out_illegal   = out_bundle_q[3];
    assign out_alu_op    = out_bundle_q[2:0];

    // Immediate extension: zero trits (2'b00) on top, no sign fill in balanced ternary.
    always_comb begin
        out_imm_ext         = '0;
        out_imm_ext[MW-1:0] = out_bundle_q[12 +: MW];
    end

endmodule
